// File: rtl/tft_spi_tx.sv
// SPI mode-0 byte serializer for the TFT panel: MSB-first shifting, registered D/C,
// and chip-select that stays low across back-to-back bytes until an idle hold expires.
module tft_spi_tx #(
    parameter int CLK_DIV = 2,
    parameter int CS_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tft_transmit,
    input  logic [7:0] tft_data,
    input  logic       tft_dc_in,
    output logic       tft_busy,
    output logic       tft_sck,
    output logic       tft_mosi,
    output logic       tft_cs,
    output logic       tft_dc
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              busy_q, busy_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              cs_q, cs_d;
    logic              dc_q, dc_d;
    logic              accept;

    // busy_q is low only in IDLE and HOLD, so it alone gates acceptance
    assign accept = tft_transmit && !busy_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        hold_cnt_d = hold_cnt_q;
        busy_d     = busy_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_d       = cs_q;
        dc_d       = dc_q;

        case (state_q)
            IDLE: begin
                cs_d = 1'b1;
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        if (bit_cnt_q == 3'd7) begin
                            // last falling edge: release busy but keep CS low for the hold window
                            busy_d     = 1'b0;
                            hold_cnt_d = '0;
                            state_d    = HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            mosi_d    = shift_q[6];
                            shift_d   = {shift_q[5:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    cs_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                sck_d   = 1'b0;
                cs_d    = 1'b1;
            end
        endcase

        // Acceptance overrides hold expiry so CS never glitches high between bytes
        if (accept) begin
            state_d   = SHIFT;
            shift_d   = tft_data[6:0];
            mosi_d    = tft_data[7];
            dc_d      = tft_dc_in;
            cs_d      = 1'b0;
            busy_d    = 1'b1;
            sck_d     = 1'b0;
            bit_cnt_d = '0;
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
            dc_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            busy_q     <= busy_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            dc_q       <= dc_d;
        end
    end

    assign tft_busy = busy_q;
    assign tft_sck  = sck_q;
    assign tft_mosi = mosi_q;
    assign tft_cs   = cs_q;
    assign tft_dc   = dc_q;

endmodule

// File: tb/tb_tft_spi_tx.sv
// Bench for tft_spi_tx: a CLK_DIV=2/CS_HOLD=4 instance under directed and random traffic,
// plus a CLK_DIV=1/CS_HOLD=1 instance for the hold-expiry/acceptance collision.
module tb_tft_spi_tx;
    localparam int A_DIV  = 2;
    localparam int A_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       tx_a = 1'b0, dcin_a = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       busy_a, sck_a, mosi_a, cs_a, dc_a;

    logic       tx_b = 1'b0, dcin_b = 1'b0;
    logic [7:0] data_b = 8'h00;
    logic       busy_b, sck_b, mosi_b, cs_b, dc_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] exp_q[$];
    int         a_rises = 0;
    int         b_rises = 0;
    int         b_cs_hi = 0;
    logic [7:0] b_bits  = 8'h00;

    always #5 clk = ~clk;

    tft_spi_tx #(.CLK_DIV(A_DIV), .CS_HOLD(A_HOLD)) dut_a (
        .clk(clk), .rst(rst), .tft_transmit(tx_a), .tft_data(data_a), .tft_dc_in(dcin_a),
        .tft_busy(busy_a), .tft_sck(sck_a), .tft_mosi(mosi_a), .tft_cs(cs_a), .tft_dc(dc_a)
    );

    tft_spi_tx #(.CLK_DIV(1), .CS_HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .tft_transmit(tx_b), .tft_data(data_b), .tft_dc_in(dcin_b),
        .tft_busy(busy_b), .tft_sck(sck_b), .tft_mosi(mosi_b), .tft_cs(cs_b), .tft_dc(dc_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference behaviour on instance A: each queued {dc,byte} must appear as exactly
    // 8 SCK rising edges carrying the byte MSB first, with busy lasting 16*CLK_DIV cycles
    // and CS released CS_HOLD cycles after busy drops unless another byte follows.
    task automatic mon_a();
        logic       p_sck  = 1'b0;
        logic       p_busy = 1'b0;
        int         nb     = 0;
        int         brun   = 0;
        int         hrun   = -1;
        logic [7:0] bits   = 8'h00;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                nb = 0; brun = 0; hrun = -1; p_sck = 1'b0; p_busy = 1'b0;
                exp_q.delete();
            end else begin
                if (sck_a && !p_sck) begin
                    a_rises++;
                    chk("a_sck_in_byte", {cs_a, busy_a}, 2'b01);
                    bits = {bits[6:0], mosi_a};
                    nb++;
                    chk("a_exp_pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        chk("a_dc_stable", dc_a, exp_q[0][8]);
                        if (nb == 8) begin
                            e = exp_q.pop_front();
                            chk("a_byte", bits, e[7:0]);
                            nb = 0;
                        end
                    end
                end
                if (busy_a) begin
                    brun++;
                end else if (p_busy) begin
                    chk("a_busy_len", brun, 16 * A_DIV);
                    brun = 0;
                    hrun = 0;
                end
                if (busy_a) begin
                    hrun = -1;
                end else if (hrun >= 0) begin
                    if (cs_a) begin
                        chk("a_cs_hold", hrun, A_HOLD);
                        hrun = -1;
                    end else begin
                        hrun++;
                    end
                end
                p_sck  = sck_a;
                p_busy = busy_a;
            end
        end
    endtask

    task automatic mon_b();
        logic p = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p = 1'b0;
            end else begin
                if (sck_b && !p) begin
                    b_rises++;
                    b_bits = {b_bits[6:0], mosi_b};
                end
                if (cs_b) b_cs_hi++;
                p = sck_b;
            end
        end
    endtask

    // Strobe on the first cycle busy is low, then confirm the acceptance took effect
    task automatic a_send(input logic [7:0] b, input logic d);
        int n = 0;
        while (busy_a && n < 200) begin step(); n++; end
        chk("a_wait_ready", busy_a, 0);
        tx_a = 1'b1; data_a = b; dcin_a = d;
        exp_q.push_back({d, b});
        step();
        tx_a = 1'b0; data_a = 8'($urandom); dcin_a = 1'($urandom);
        chk("a_busy_after_acc", busy_a, 1);
        chk("a_cs_after_acc", cs_a, 0);
        chk("a_dc_after_acc", dc_a, d);
    endtask

    task automatic a_junk(input logic [7:0] b);
        tx_a = 1'b1; data_a = b; dcin_a = ~dcin_a;
        step();
        tx_a = 1'b0;
    endtask

    task automatic a_idle();
        int n = 0;
        while (!(cs_a && !busy_a) && n < 300) begin step(); n++; end
        chk("a_reach_idle", {cs_a, busy_a}, 2'b10);
    endtask

    task automatic b_send(input logic [7:0] b, input logic d);
        int n = 0;
        while (busy_b && n < 200) begin step(); n++; end
        chk("b_wait_ready", busy_b, 0);
        tx_b = 1'b1; data_b = b; dcin_b = d;
        step();
        tx_b = 1'b0; data_b = 8'($urandom);
        chk("b_busy_after_acc", busy_b, 1);
        chk("b_cs_after_acc", cs_b, 0);
        chk("b_dc_after_acc", dc_b, d);
    endtask

    initial begin
        int r0, c0, n;
        logic [7:0] rb;
        fork
            mon_a();
            mon_b();
        join_none

        repeat (3) step();
        chk("a_rst_outs", {busy_a, sck_a, mosi_a, cs_a, dc_a}, 5'b00011);
        chk("b_rst_outs", {busy_b, sck_b, mosi_b, cs_b, dc_b}, 5'b00011);
        rst = 1'b0;
        step();

        // single byte
        r0 = a_rises;
        a_send(8'hA5, 1'b1);
        a_idle();
        chk("a_rises_single", a_rises - r0, 8);

        // back-to-back burst
        r0 = a_rises;
        a_send(8'h3A, 1'b1);
        a_send(8'h7B, 1'b1);
        a_send(8'hD5, 1'b1);
        a_idle();
        chk("a_rises_burst", a_rises - r0, 24);

        // strobe while busy is ignored
        r0 = a_rises;
        a_send(8'h00, 1'b1);
        repeat (5) step();
        a_junk(8'hFF);
        a_idle();
        chk("a_rises_ignored", a_rises - r0, 8);

        // command then data
        a_send(8'h2C, 1'b0);
        a_send(8'h12, 1'b1);
        a_idle();
        chk("a_dc_final", dc_a, 1);

        // reset mid-byte
        r0 = a_rises;
        a_send(8'h81, 1'b1);
        n = 0;
        while (a_rises < r0 + 3 && n < 200) begin step(); n++; end
        chk("a_third_rise", a_rises - r0, 3);
        rst = 1'b1;
        step();
        chk("a_midrst_outs", {busy_a, sck_a, mosi_a, cs_a, dc_a}, 5'b00011);
        rst = 1'b0;
        step();
        r0 = a_rises;
        a_send(8'h3C, 1'b0);
        a_idle();
        chk("a_rises_after_rst", a_rises - r0, 8);

        // randomized traffic
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 7)) step();
            rb = 8'($urandom);
            a_send(rb, 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 20)) step();
                a_junk(8'($urandom));
            end
        end
        a_idle();

        // CLK_DIV=1, CS_HOLD=1: strobe lands on the hold-expiry edge
        r0 = b_rises;
        b_send(8'h5A, 1'b1);
        c0 = b_cs_hi;
        b_send(8'h96, 1'b0);
        chk("b_first_byte", b_bits, 8'h5A);
        n = 0;
        while (busy_b && n < 100) begin step(); n++; end
        chk("b_busy_fell", busy_b, 0);
        chk("b_cs_no_glitch", b_cs_hi - c0, 0);
        chk("b_rises", b_rises - r0, 16);
        chk("b_second_byte", b_bits, 8'h96);
        chk("b_dc", dc_b, 0);
        step();
        chk("b_cs_release", cs_b, 1);

        chk("a_exp_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
